// File: rtl/conv2d_1x1.sv
// One squeeze-layer 1x1 convolution PE: 16-lane multiply, balanced adder tree,
// cross-beat accumulation and bias/ReLU on the last channel-group beat of a cell.
module conv2d_1x1 #(
   parameter int LANES  = 16,
   parameter int DATA_W = 8,
   parameter int BIAS_W = 16,
   parameter int ACC_W  = 32,
   parameter int RELU   = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_data_valid,
   input  logic [LANES*DATA_W-1:0]   imgdata,
   input  logic [LANES*DATA_W-1:0]   kernel,
   input  logic                      i_last,
   input  logic [BIAS_W-1:0]         bias,
   output logic [ACC_W-1:0]          o_convolved_data,
   output logic                      o_convolved_data_valid
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int LEVELS = $clog2(LANES);
   localparam int P2     = 1 << LEVELS;

   function automatic logic signed [PROD_W-1:0] lane_mul(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      return PROD_W'(a) * PROD_W'(b);
   endfunction

   // Stage 1: per-lane full-precision products
   logic signed [PROD_W-1:0] prod_q [LANES];
   logic                     s1_valid;
   logic                     s1_last;
   logic signed [ACC_W-1:0]  s1_bias;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < LANES; i++) prod_q[i] <= '0;
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_bias  <= '0;
      end else begin
         s1_valid <= i_data_valid;
         s1_last  <= i_data_valid & i_last;
         if (i_data_valid) begin
            for (int unsigned i = 0; i < LANES; i++)
               prod_q[i] <= lane_mul(imgdata[DATA_W*i +: DATA_W], kernel[DATA_W*i +: DATA_W]);
            if (i_last) s1_bias <= ACC_W'($signed(bias));
         end
      end
   end

   // Balanced tree, padded with zero leaves up to the next power of two
   genvar lv, n;
   for (lv = 0; lv <= LEVELS; lv++) begin : g_lvl
      logic signed [ACC_W-1:0] node [P2 >> lv];
      if (lv == 0) begin : g_leaf
         for (n = 0; n < P2; n++) begin : g_n
            if (n < LANES) begin : g_used
               assign node[n] = ACC_W'(prod_q[n]);
            end else begin : g_pad
               assign node[n] = '0;
            end
         end
      end else begin : g_add
         for (n = 0; n < (P2 >> lv); n++) begin : g_n
            assign node[n] = g_lvl[lv-1].node[2*n] + g_lvl[lv-1].node[2*n+1];
         end
      end
   end

   logic signed [ACC_W-1:0] tree_sum;
   assign tree_sum = g_lvl[LEVELS].node[0];

   // Stage 2: registered beat sum
   logic signed [ACC_W-1:0] s2_sum;
   logic signed [ACC_W-1:0] s2_bias;
   logic                    s2_valid;
   logic                    s2_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_sum   <= '0;
         s2_bias  <= '0;
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
      end else begin
         s2_sum   <= tree_sum;
         s2_bias  <= s1_bias;
         s2_valid <= s1_valid;
         s2_last  <= s1_last;
      end
   end

   // Stage 3: accumulate, finalize on last beat
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] result;

   always_comb begin
      result = acc + s2_sum + s2_bias;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc                    <= '0;
         o_convolved_data       <= '0;
         o_convolved_data_valid <= 1'b0;
      end else begin
         o_convolved_data_valid <= 1'b0;
         if (s2_valid) begin
            if (s2_last) begin
               o_convolved_data       <= (RELU != 0 && result[ACC_W-1]) ? '0 : result;
               o_convolved_data_valid <= 1'b1;
               acc                    <= '0;
            end else begin
               acc <= acc + s2_sum;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv2d_1x1.sv
// Directed bench for conv2d_1x1: a ReLU and a linear instance share one input bus.
module tb_conv2d_1x1;

   localparam int LANES  = 16;
   localparam int DATA_W = 8;
   localparam int BIAS_W = 16;
   localparam int ACC_W  = 32;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    i_data_valid;
   logic [LANES*DATA_W-1:0] imgdata;
   logic [LANES*DATA_W-1:0] kernel;
   logic                    i_last;
   logic [BIAS_W-1:0]       bias;
   logic [ACC_W-1:0]        data_relu, data_lin;
   logic                    valid_relu, valid_lin;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [ACC_W-1:0] q_relu [$];
   logic [ACC_W-1:0] q_lin  [$];
   int               q_cyc  [$];

   conv2d_1x1 #(.LANES(LANES), .DATA_W(DATA_W), .BIAS_W(BIAS_W), .ACC_W(ACC_W), .RELU(1)) dut_relu (
      .clk(clk), .rst(rst), .i_data_valid(i_data_valid), .imgdata(imgdata), .kernel(kernel),
      .i_last(i_last), .bias(bias), .o_convolved_data(data_relu), .o_convolved_data_valid(valid_relu)
   );

   conv2d_1x1 #(.LANES(LANES), .DATA_W(DATA_W), .BIAS_W(BIAS_W), .ACC_W(ACC_W), .RELU(0)) dut_lin (
      .clk(clk), .rst(rst), .i_data_valid(i_data_valid), .imgdata(imgdata), .kernel(kernel),
      .i_last(i_last), .bias(bias), .o_convolved_data(data_lin), .o_convolved_data_valid(valid_lin)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (!rst && valid_relu) q_relu.push_back(data_relu);
      if (!rst && valid_lin) begin
         q_lin.push_back(data_lin);
         q_cyc.push_back(cyc);
      end
   end

   function automatic logic [LANES*DATA_W-1:0] fill(input logic [DATA_W-1:0] v);
      return {LANES{v}};
   endfunction

   task automatic clear_q();
      q_relu.delete();
      q_lin.delete();
      q_cyc.delete();
   endtask

   task automatic beat(input logic [DATA_W-1:0] px, input logic [DATA_W-1:0] wt,
                       input logic lst, input logic [BIAS_W-1:0] b);
      i_data_valid = 1'b1;
      imgdata      = fill(px);
      kernel       = fill(wt);
      i_last       = lst;
      bias         = b;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      i_data_valid = 1'b0;
      i_last       = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (valid_relu !== 1'b0 || valid_lin !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid cyc=%0d got relu=%b lin=%b expected 0", c, valid_relu, valid_lin);
         end
         checks++;
         if (data_relu !== '0 || data_lin !== '0) begin
            errors++;
            $display("FAIL reset_data cyc=%0d got relu=%0d lin=%0d expected 0", c, data_relu, data_lin);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_single();
      clear_q();
      beat(8'd1, 8'd2, 1'b1, 16'd5);
      i_data_valid = 1'b0;
      i_last       = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         checks++;
         if (valid_lin !== (c == 3)) begin
            errors++;
            $display("FAIL single_latency cyc=%0d got valid=%b expected %b", c, valid_lin, (c == 3));
         end
         if (c >= 3) begin
            checks++;
            if ($signed(data_lin) !== 37 || $signed(data_relu) !== 37) begin
               errors++;
               $display("FAIL single_data cyc=%0d got lin=%0d relu=%0d expected 37",
                        c, $signed(data_lin), $signed(data_relu));
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_four_beat();
      clear_q();
      for (int b = 0; b < 4; b++) beat(8'd3, 8'hFF, (b == 3), 16'd10);
      idle(6);
      checks++;
      if (q_relu.size() != 1 || q_lin.size() != 1) begin
         errors++;
         $display("FAIL four_beat_strobes got relu=%0d lin=%0d expected 1", q_relu.size(), q_lin.size());
      end else begin
         checks++;
         if ($signed(q_relu[0]) !== 0) begin
            errors++;
            $display("FAIL four_beat_relu got %0d expected 0", $signed(q_relu[0]));
         end
         checks++;
         if ($signed(q_lin[0]) !== -182) begin
            errors++;
            $display("FAIL four_beat_lin got %0d expected -182", $signed(q_lin[0]));
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_q();
      beat(8'd1, 8'd1, 1'b0, 16'd0);
      beat(8'd1, 8'd1, 1'b1, 16'd0);
      beat(8'd2, 8'd2, 1'b1, 16'd1);
      idle(1);
      idle(6);
      checks++;
      if (q_lin.size() != 2 || q_relu.size() != 2) begin
         errors++;
         $display("FAIL b2b_strobes got lin=%0d relu=%0d expected 2", q_lin.size(), q_relu.size());
      end else begin
         checks++;
         if ($signed(q_lin[0]) !== 32 || $signed(q_relu[0]) !== 32) begin
            errors++;
            $display("FAIL b2b_cell_a got lin=%0d relu=%0d expected 32", $signed(q_lin[0]), $signed(q_relu[0]));
         end
         checks++;
         if ($signed(q_lin[1]) !== 65 || $signed(q_relu[1]) !== 65) begin
            errors++;
            $display("FAIL b2b_cell_b got lin=%0d relu=%0d expected 65", $signed(q_lin[1]), $signed(q_relu[1]));
         end
         checks++;
         if (q_cyc[1] - q_cyc[0] != 1) begin
            errors++;
            $display("FAIL b2b_spacing got %0d cycles expected 1", q_cyc[1] - q_cyc[0]);
         end
      end
   endtask

   task automatic test_extremes();
      clear_q();
      for (int b = 0; b < 32; b++) beat(8'h80, 8'h80, (b == 31), 16'h7FFF);
      idle(6);
      checks++;
      if (q_lin.size() != 1 || q_relu.size() != 1) begin
         errors++;
         $display("FAIL extremes_strobes got lin=%0d relu=%0d expected 1", q_lin.size(), q_relu.size());
      end else begin
         checks++;
         if ($signed(q_lin[0]) !== 8421375 || $signed(q_relu[0]) !== 8421375) begin
            errors++;
            $display("FAIL extremes_data got lin=%0d relu=%0d expected 8421375",
                     $signed(q_lin[0]), $signed(q_relu[0]));
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_q();
      beat(8'd5, 8'd7, 1'b0, 16'd3);
      beat(8'd5, 8'd7, 1'b0, 16'd3);
      i_data_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      beat(8'd1, 8'd1, 1'b1, 16'd0);
      idle(6);
      checks++;
      if (q_lin.size() != 1 || q_relu.size() != 1) begin
         errors++;
         $display("FAIL reset_mid_strobes got lin=%0d relu=%0d expected 1", q_lin.size(), q_relu.size());
      end else begin
         checks++;
         if ($signed(q_lin[0]) !== 16 || $signed(q_relu[0]) !== 16) begin
            errors++;
            $display("FAIL reset_mid_data got lin=%0d relu=%0d expected 16",
                     $signed(q_lin[0]), $signed(q_relu[0]));
         end
      end
   endtask

   initial begin
      rst          = 1'b1;
      i_data_valid = 1'b0;
      imgdata      = '0;
      kernel       = '0;
      i_last       = 1'b0;
      bias         = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_four_beat();
      test_back_to_back();
      test_extremes();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
